// File: rtl/branch_resolution.sv
// rtl/branch_resolution.sv - beq/bne/j resolution with PC redirect handshake, flush window and saturating counters
module branch_resolution #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [5:0]       instruccion,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic [31:0]      pc_plus4,
  input  logic [15:0]      imm,
  input  logic [25:0]      jaddr,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  input  logic             redir_ready,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EVAL  = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  // Counter is kept at least 1 bit wide so FLUSH_CYCLES=0 still elaborates.
  localparam int FW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  logic [1:0]       r_state;
  logic [5:0]       r_op;
  logic [31:0]      r_rs;
  logic [31:0]      r_rt;
  logic [31:0]      r_pc4;
  logic [15:0]      r_imm;
  logic [25:0]      r_jaddr;
  logic [31:0]      r_redir_pc;
  logic [FW-1:0]    r_flush_cnt;
  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_taken_count;

  logic        w_is_branch;
  logic        w_taken;
  logic [31:0] w_target;

  assign w_is_branch = (instruccion == OP_BEQ) || (instruccion == OP_BNE) ||
                       (instruccion == OP_J);

  always_comb begin
    w_taken  = 1'b1;
    w_target = {r_pc4[31:28], r_jaddr, 2'b00};
    if (r_op == OP_BEQ || r_op == OP_BNE) begin
      w_taken  = (r_op == OP_BEQ) ? (r_rs == r_rt) : (r_rs != r_rt);
      w_target = r_pc4 + {{14{r_imm[15]}}, r_imm, 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_op           <= '0;
      r_rs           <= '0;
      r_rt           <= '0;
      r_pc4          <= '0;
      r_imm          <= '0;
      r_jaddr        <= '0;
      r_redir_pc     <= '0;
      r_flush_cnt    <= '0;
      r_branch_count <= '0;
      r_taken_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (br_valid) begin
            r_op    <= instruccion;
            r_rs    <= rs_val;
            r_rt    <= rt_val;
            r_pc4   <= pc_plus4;
            r_imm   <= imm;
            r_jaddr <= jaddr;
            if (w_is_branch) r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (r_branch_count != '1) r_branch_count <= r_branch_count + CNT_W'(1);
          if (w_taken) begin
            if (r_taken_count != '1) r_taken_count <= r_taken_count + CNT_W'(1);
            r_redir_pc <= w_target;
            r_state    <= S_REDIR;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REDIR: begin
          if (redir_ready) begin
            if (FLUSH_CYCLES > 0) begin
              r_flush_cnt <= FW'(FLUSH_CYCLES);
              r_state     <= S_FLUSH;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_flush_cnt <= r_flush_cnt - FW'(1);
          if (r_flush_cnt <= FW'(1)) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign br_ready     = (r_state == S_IDLE);
  assign redir_valid  = (r_state == S_REDIR);
  assign flush        = (r_state == S_FLUSH);
  assign redir_pc     = r_redir_pc;
  assign branch_count = r_branch_count;
  assign taken_count  = r_taken_count;

endmodule

// File: tb/tb_branch_resolution.sv
// tb/tb_branch_resolution.sv - randomized model-checked bench for branch_resolution (two parameterisations)
module tb_branch_resolution;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, br_valid = 1'b0, redir_ready = 1'b0;
  logic [5:0]  instruccion = '0;
  logic [31:0] rs_val = '0, rt_val = '0, pc_plus4 = '0;
  logic [15:0] imm = '0;
  logic [25:0] jaddr = '0;

  logic        a_br_ready, a_redir_valid, a_flush;
  logic [31:0] a_redir_pc;
  logic [15:0] a_branch_count, a_taken_count;
  logic        b_br_ready, b_redir_valid, b_flush;
  logic [31:0] b_redir_pc;
  logic [1:0]  b_branch_count, b_taken_count;

  branch_resolution #(.FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(a_br_ready),
    .instruccion(instruccion), .rs_val(rs_val), .rt_val(rt_val), .pc_plus4(pc_plus4),
    .imm(imm), .jaddr(jaddr), .redir_valid(a_redir_valid), .redir_pc(a_redir_pc),
    .redir_ready(redir_ready), .flush(a_flush), .branch_count(a_branch_count),
    .taken_count(a_taken_count));

  branch_resolution #(.FLUSH_CYCLES(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(b_br_ready),
    .instruccion(instruccion), .rs_val(rs_val), .rt_val(rt_val), .pc_plus4(pc_plus4),
    .imm(imm), .jaddr(jaddr), .redir_valid(b_redir_valid), .redir_pc(b_redir_pc),
    .redir_ready(redir_ready), .flush(b_flush), .branch_count(b_branch_count),
    .taken_count(b_taken_count));

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;
  bit b_flush_seen = 1'b0;

  // Model: pending evaluation, outstanding redirect, flush cycles left, counts.
  typedef struct {
    bit          ev;
    bit          tk;
    logic [31:0] tgt;
    bit          rv;
    logic [31:0] rpc;
    int          fl;
    int          bc;
    int          tc;
  } model_t;

  model_t ma, mb;

  function automatic model_t reset_model();
    model_t m;
    m.ev = 0; m.tk = 0; m.tgt = '0; m.rv = 0; m.rpc = '0; m.fl = 0; m.bc = 0; m.tc = 0;
    return m;
  endfunction

  function automatic model_t step(model_t m, int fc, int cmax);
    model_t n = m;
    int off;
    if (rst) return reset_model();
    if (m.ev) begin
      n.ev = 0;
      n.bc = (m.bc < cmax) ? m.bc + 1 : cmax;
      if (m.tk) begin
        n.tc  = (m.tc < cmax) ? m.tc + 1 : cmax;
        n.rv  = 1;
        n.rpc = m.tgt;
      end
    end else if (m.rv) begin
      if (redir_ready) begin
        n.rv = 0;
        n.fl = fc;
      end
    end else if (m.fl > 0) begin
      n.fl = m.fl - 1;
    end else if (br_valid && (instruccion == 6'd4 || instruccion == 6'd5 || instruccion == 6'd2)) begin
      n.ev = 1;
      off  = $signed(imm);
      if (instruccion == 6'd2) begin
        n.tk  = 1;
        n.tgt = {pc_plus4[31:28], jaddr, 2'b00};
      end else begin
        n.tk  = (instruccion == 6'd4) ? (rs_val == rt_val) : (rs_val != rt_val);
        n.tgt = pc_plus4 + 32'(off * 4);
      end
    end
    return n;
  endfunction

  initial begin
    ma = reset_model();
    mb = reset_model();
  end

  always @(posedge clk) begin
    ma <= step(ma, 2, 65535);
    mb <= step(mb, 0, 3);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("a_br_ready",     32'(a_br_ready),     32'(!ma.ev && !ma.rv && ma.fl == 0));
      chk("a_redir_valid",  32'(a_redir_valid),  32'(ma.rv));
      chk("a_redir_pc",     a_redir_pc,          ma.rpc);
      chk("a_flush",        32'(a_flush),        32'(ma.fl > 0));
      chk("a_branch_count", 32'(a_branch_count), 32'(ma.bc));
      chk("a_taken_count",  32'(a_taken_count),  32'(ma.tc));
      chk("b_br_ready",     32'(b_br_ready),     32'(!mb.ev && !mb.rv && mb.fl == 0));
      chk("b_redir_valid",  32'(b_redir_valid),  32'(mb.rv));
      chk("b_redir_pc",     b_redir_pc,          mb.rpc);
      chk("b_flush",        32'(b_flush),        32'(mb.fl > 0));
      chk("b_branch_count", 32'(b_branch_count), 32'(mb.bc));
      chk("b_taken_count",  32'(b_taken_count),  32'(mb.tc));
      if (b_flush) b_flush_seen = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] pc, input logic [15:0] im, input logic [25:0] ja);
    br_valid = 1'b1; instruccion = op; rs_val = rs; rt_val = rt;
    pc_plus4 = pc; imm = im; jaddr = ja;
    tick();
    br_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    started = 1'b1;
    chk("rst_br_ready", 32'(a_br_ready), 32'd1);
    chk("rst_redir_valid", 32'(a_redir_valid), 32'd0);
    chk("rst_flush", 32'(a_flush), 32'd0);
    chk("rst_counts", {a_branch_count, a_taken_count}, 32'd0);

    // beq taken, backward offset
    redir_ready = 1'b1;
    issue(6'd4, 32'd5, 32'd5, 32'h100, 16'hFFFE, 26'd0);
    chk("beq_eval_not_ready", 32'(a_br_ready), 32'd0);
    tick();
    chk("beq_redir_valid", 32'(a_redir_valid), 32'd1);
    chk("beq_redir_pc", a_redir_pc, 32'h0000_00F8);
    chk("beq_counts", {a_branch_count, a_taken_count}, {16'd1, 16'd1});
    tick();
    chk("beq_flush1", 32'(a_flush), 32'd1);
    chk("beq_redir_drop", 32'(a_redir_valid), 32'd0);
    chk("b_idle_after_hs", 32'({b_br_ready, b_flush}), 32'b10);
    tick();
    chk("beq_flush2", 32'(a_flush), 32'd1);
    tick();
    chk("beq_flush_end", 32'({a_flush, a_br_ready}), 32'b01);

    // bne not taken, then a non-branch opcode
    do_reset();
    issue(6'd5, 32'd7, 32'd7, 32'h200, 16'h0010, 26'd0);
    tick();
    chk("bne_ready_back", 32'({a_br_ready, a_redir_valid, a_flush}), 32'b100);
    chk("bne_counts", {a_branch_count, a_taken_count}, {16'd1, 16'd0});
    issue(6'd0, 32'd1, 32'd1, 32'h300, 16'h0001, 26'd1);
    tick();
    chk("nonbr_counts", {a_branch_count, a_taken_count}, {16'd1, 16'd0});
    chk("nonbr_ready", 32'(a_br_ready), 32'd1);

    // j with fetch stalling the redirect
    do_reset();
    redir_ready = 1'b0;
    issue(6'd2, 32'd0, 32'd0, 32'h4000_0010, 16'd0, 26'h40);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("j_stall_valid", 32'({a_redir_valid, a_flush}), 32'b10);
      chk("j_stall_pc", a_redir_pc, 32'h4000_0100);
      if (i < 2) tick();
    end
    redir_ready = 1'b1;
    tick();
    chk("j_flush_after_hs", 32'({a_redir_valid, a_flush}), 32'b01);

    // reset during REDIRECT
    do_reset();
    redir_ready = 1'b0;
    issue(6'd2, 32'd0, 32'd0, 32'h1000_0000, 16'd0, 26'h3);
    tick();
    chk("rr_in_redirect", 32'(a_redir_valid), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rr_after", 32'({a_br_ready, a_redir_valid, a_flush}), 32'b100);
    chk("rr_counts", {a_branch_count, a_taken_count}, 32'd0);

    // reset during the second flush cycle
    redir_ready = 1'b1;
    issue(6'd2, 32'd0, 32'd0, 32'h1000_0000, 16'd0, 26'h3);
    tick(); tick(); tick();
    chk("rf_flush2", 32'(a_flush), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rf_after", 32'({a_br_ready, a_redir_valid, a_flush}), 32'b100);
    chk("rf_counts", {a_branch_count, a_taken_count}, 32'd0);

    // back-to-back taken jumps: narrow counters saturate
    do_reset();
    redir_ready = 1'b1;
    br_valid = 1'b1; instruccion = 6'd2; jaddr = 26'h10; pc_plus4 = 32'h0;
    repeat (30) tick();
    br_valid = 1'b0;
    repeat (4) tick();
    chk("sat_b_counts", 32'({b_branch_count, b_taken_count}), 32'hF);
    chk("sat_a_counts", {a_branch_count, a_taken_count}, {16'd6, 16'd6});

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 149) == 0);
      br_valid = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: instruccion = 6'd4;
        1: instruccion = 6'd5;
        2: instruccion = 6'd2;
        default: instruccion = 6'($urandom);
      endcase
      rs_val      = $urandom;
      rt_val      = $urandom_range(0, 1) ? rs_val : $urandom;
      pc_plus4    = $urandom;
      imm         = 16'($urandom);
      jaddr       = 26'($urandom);
      redir_ready = ($urandom_range(0, 4) < 3);
      tick();
    end
    rst = 1'b0;
    tick();

    chk("b_flush_never", 32'(b_flush_seen), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
